// File: rtl/vx_barrier_pkg.sv
// Shared types and width helpers for the per-core warp barrier unit.
package vx_barrier_pkg;

  function automatic int bits_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_WARPS_DEF    = 4;
  localparam int NUM_BARRIERS_DEF = 4;
  localparam int NW_BITS          = bits_min1(NUM_WARPS_DEF);
  localparam int NB_BITS          = bits_min1(NUM_BARRIERS_DEF);

  typedef struct packed {
    logic [NW_BITS-1:0] wid;
    logic [NB_BITS-1:0] bar_id;
    logic [NW_BITS-1:0] size_m1;
  } bar_req_t;

  typedef enum logic {
    IDLE    = 1'b0,
    RELEASE = 1'b1
  } bar_state_t;

endpackage

// File: rtl/vx_popcount.sv
// Counts set bits across an N-wide vector.
module vx_popcount #(
  parameter int N     = 4,
  parameter int CNT_W = 3
) (
  input  logic [N-1:0]     bits_in,
  output logic [CNT_W-1:0] cnt
);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + CNT_W'(bits_in[i]);
    end
  end

endmodule

// File: rtl/vx_barrier_unit.sv
// Per-core warp barrier controller: tracks waiting warps per barrier, drives the
// scheduler stall mask and pulses a release once the expected count arrives.
module vx_barrier_unit
  import vx_barrier_pkg::*;
#(
  parameter int NUM_WARPS    = NUM_WARPS_DEF,
  parameter int NUM_BARRIERS = NUM_BARRIERS_DEF,
  localparam int WB          = bits_min1(NUM_WARPS),
  localparam int BB          = bits_min1(NUM_BARRIERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [WB-1:0]        req_wid,
  input  logic [BB-1:0]        req_bar_id,
  input  logic [WB-1:0]        req_size_m1,
  input  logic                 kill_valid,
  input  logic [WB-1:0]        kill_wid,
  output logic                 rel_valid,
  output logic [BB-1:0]        rel_bar_id,
  output logic [NUM_WARPS-1:0] rel_mask,
  output logic [NUM_WARPS-1:0] stall_mask,
  output logic                 err,
  input  logic                 err_clr,
  output logic                 busy
);

  bar_req_t             req;
  bar_state_t           state_q, state_d;

  logic [NUM_WARPS-1:0] mask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_k [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_d [NUM_BARRIERS];
  logic [WB-1:0]        size_q [NUM_BARRIERS];
  logic [WB-1:0]        size_d [NUM_BARRIERS];

  logic [NUM_WARPS-1:0] kill_oh, req_oh, sel_mask;
  logic [WB:0]          cnt;
  logic [WB-1:0]        eff_size;
  logic                 accept, kill_same, dup, other;
  logic                 rel_valid_d, err_d, busy_d;
  logic [BB-1:0]        rel_bar_id_d;
  logic [NUM_WARPS-1:0] rel_mask_d, stall_d;

  assign req       = '{wid: req_wid, bar_id: req_bar_id, size_m1: req_size_m1};
  assign req_ready = reset & (state_q == IDLE);
  assign accept    = req_valid & req_ready;
  assign kill_same = kill_valid & (kill_wid == req.wid);

  always_comb begin
    kill_oh = '0;
    if (kill_valid) kill_oh[kill_wid] = 1'b1;
  end

  always_comb begin
    req_oh = '0;
    req_oh[req.wid] = 1'b1;
  end

  // Kill is folded in first so every arrival decision sees the post-kill masks.
  always_comb begin
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      mask_k[b] = mask_q[b] & ~kill_oh;
    end
  end

  assign sel_mask = mask_k[req.bar_id];
  assign dup      = sel_mask[req.wid];

  always_comb begin
    other = 1'b0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      if ((BB'(b) != req.bar_id) && mask_k[b][req.wid]) other = 1'b1;
    end
  end

  vx_popcount #(
    .N     (NUM_WARPS),
    .CNT_W (WB + 1)
  ) u_popcount (
    .bits_in (sel_mask),
    .cnt     (cnt)
  );

  always_comb begin
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      mask_d[b] = mask_k[b];
      size_d[b] = size_q[b];
    end
    state_d      = IDLE;
    rel_valid_d  = 1'b0;
    rel_bar_id_d = '0;
    rel_mask_d   = '0;
    eff_size     = '0;
    err_d        = err & ~err_clr;

    if (accept && !kill_same) begin
      if (dup || other) begin
        err_d = 1'b1;
      end else begin
        if (cnt == '0) begin
          size_d[req.bar_id] = req.size_m1;
          eff_size           = req.size_m1;
        end else begin
          eff_size = size_q[req.bar_id];
          if (req.size_m1 != size_q[req.bar_id]) err_d = 1'b1;
        end

        if (cnt == {1'b0, eff_size}) begin
          mask_d[req.bar_id] = '0;
          rel_valid_d        = 1'b1;
          rel_bar_id_d       = req.bar_id;
          rel_mask_d         = sel_mask | req_oh;
          state_d            = RELEASE;
        end else begin
          mask_d[req.bar_id][req.wid] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    stall_d = '0;
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stall_d = stall_d | mask_d[b];
    end
  end

  assign busy_d = |stall_d;

  // Register boundary: barrier state and all scheduler-facing outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= '0;
        size_q[b] <= '0;
      end
      state_q    <= IDLE;
      rel_valid  <= 1'b0;
      rel_bar_id <= '0;
      rel_mask   <= '0;
      stall_mask <= '0;
      busy       <= 1'b0;
      err        <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= mask_d[b];
        size_q[b] <= size_d[b];
      end
      state_q    <= state_d;
      rel_valid  <= rel_valid_d;
      rel_bar_id <= rel_bar_id_d;
      rel_mask   <= rel_mask_d;
      stall_mask <= stall_d;
      busy       <= busy_d;
      err        <= err_d;
    end
  end

endmodule

// File: tb/tb_vx_barrier_unit.sv
// Directed bench for vx_barrier_unit with hand-computed expectations.
module tb_vx_barrier_unit;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_wid;
  logic [1:0] req_bar_id;
  logic [1:0] req_size_m1;
  logic       kill_valid;
  logic [1:0] kill_wid;
  logic       rel_valid;
  logic [1:0] rel_bar_id;
  logic [3:0] rel_mask;
  logic [3:0] stall_mask;
  logic       err;
  logic       err_clr;
  logic       busy;

  int n_tests = 0;
  int n_fail  = 0;

  vx_barrier_unit dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_wid     (req_wid),
    .req_bar_id  (req_bar_id),
    .req_size_m1 (req_size_m1),
    .kill_valid  (kill_valid),
    .kill_wid    (kill_wid),
    .rel_valid   (rel_valid),
    .rel_bar_id  (rel_bar_id),
    .rel_mask    (rel_mask),
    .stall_mask  (stall_mask),
    .err         (err),
    .err_clr     (err_clr),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic arrive(input logic [1:0] w, input logic [1:0] b, input logic [1:0] s);
    req_valid   = 1'b1;
    req_wid     = w;
    req_bar_id  = b;
    req_size_m1 = s;
    step();
    req_valid   = 1'b0;
  endtask

  task automatic kill_only(input logic [1:0] w);
    kill_valid = 1'b1;
    kill_wid   = w;
    step();
    kill_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_wid = '0; req_bar_id = '0; req_size_m1 = '0;
    kill_valid = 1'b0; kill_wid = '0; err_clr = 1'b0;
    #2 reset = 1'b0;
    #2;
    chk("rst_ready", 32'(req_ready), 'h0);
    chk("rst_stall", 32'(stall_mask), 'h0);
    chk("rst_relv", 32'(rel_valid), 'h0);
    chk("rst_err", 32'(err), 'h0);
    chk("rst_busy", 32'(busy), 'h0);
    #18 reset = 1'b1;
    step();
    chk("ready_idle", 32'(req_ready), 'h1);

    // three warps on barrier 1, size 3
    arrive(2'd0, 2'd1, 2'd2);
    chk("t1_stall_a", 32'(stall_mask), 'b0001);
    chk("t1_busy_a", 32'(busy), 'h1);
    arrive(2'd2, 2'd1, 2'd2);
    chk("t1_stall_b", 32'(stall_mask), 'b0101);
    chk("t1_relv_b", 32'(rel_valid), 'h0);
    arrive(2'd3, 2'd1, 2'd2);
    chk("t1_relv", 32'(rel_valid), 'h1);
    chk("t1_relbar", 32'(rel_bar_id), 'h1);
    chk("t1_relmask", 32'(rel_mask), 'b1101);
    chk("t1_stall_c", 32'(stall_mask), 'b0000);
    chk("t1_ready_rel", 32'(req_ready), 'h0);
    chk("t1_busy_c", 32'(busy), 'h0);
    step();
    chk("t1_relv_off", 32'(rel_valid), 'h0);
    chk("t1_relmask_off", 32'(rel_mask), 'h0);
    chk("t1_ready_back", 32'(req_ready), 'h1);

    // single-warp barrier releases at once
    arrive(2'd2, 2'd0, 2'd0);
    chk("t2_relv", 32'(rel_valid), 'h1);
    chk("t2_relbar", 32'(rel_bar_id), 'h0);
    chk("t2_relmask", 32'(rel_mask), 'b0100);
    chk("t2_stall", 32'(stall_mask), 'b0000);
    step();
    chk("t2_stall_after", 32'(stall_mask), 'b0000);

    // duplicate arrival
    arrive(2'd1, 2'd0, 2'd1);
    chk("t3_stall", 32'(stall_mask), 'b0010);
    chk("t3_err0", 32'(err), 'h0);
    arrive(2'd1, 2'd0, 2'd1);
    chk("t3_err", 32'(err), 'h1);
    chk("t3_relv", 32'(rel_valid), 'h0);
    chk("t3_stall_keep", 32'(stall_mask), 'b0010);
    err_clr = 1'b1;
    arrive(2'd1, 2'd0, 2'd1);
    chk("t3_clr_vs_err", 32'(err), 'h1);
    step();
    err_clr = 1'b0;
    chk("t3_err_clr", 32'(err), 'h0);
    kill_only(2'd1);
    chk("t3_kill_stall", 32'(stall_mask), 'b0000);
    chk("t3_kill_busy", 32'(busy), 'h0);
    chk("t3_kill_relv", 32'(rel_valid), 'h0);

    // size mismatch keeps the latched size
    arrive(2'd0, 2'd1, 2'd2);
    arrive(2'd2, 2'd1, 2'd1);
    chk("t4_mis_err", 32'(err), 'h1);
    chk("t4_mis_relv", 32'(rel_valid), 'h0);
    chk("t4_mis_stall", 32'(stall_mask), 'b0101);
    arrive(2'd3, 2'd1, 2'd1);
    chk("t4_mis_rel", 32'(rel_valid), 'h1);
    chk("t4_mis_mask", 32'(rel_mask), 'b1101);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t4_err_clr", 32'(err), 'h0);

    // warp waiting elsewhere
    arrive(2'd0, 2'd2, 2'd1);
    arrive(2'd0, 2'd3, 2'd1);
    chk("t5_other_err", 32'(err), 'h1);
    chk("t5_other_stall", 32'(stall_mask), 'b0001);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    // kill of warp 0 plus arrival of warp 3 on barrier 2
    kill_valid = 1'b1;
    kill_wid   = 2'd0;
    arrive(2'd3, 2'd2, 2'd1);
    kill_valid = 1'b0;
    chk("t6_relv", 32'(rel_valid), 'h0);
    chk("t6_stall", 32'(stall_mask), 'b1000);
    chk("t6_err", 32'(err), 'h0);
    arrive(2'd1, 2'd2, 2'd1);
    chk("t6_rel", 32'(rel_valid), 'h1);
    chk("t6_relbar", 32'(rel_bar_id), 'h2);
    chk("t6_relmask", 32'(rel_mask), 'b1010);
    step();

    // kill and arrival of the same warp: kill wins
    kill_valid = 1'b1;
    kill_wid   = 2'd2;
    arrive(2'd2, 2'd1, 2'd0);
    kill_valid = 1'b0;
    chk("t7_same_relv", 32'(rel_valid), 'h0);
    chk("t7_same_err", 32'(err), 'h0);
    chk("t7_same_stall", 32'(stall_mask), 'b0000);

    // asynchronous reset mid-operation
    arrive(2'd0, 2'd3, 2'd3);
    arrive(2'd1, 2'd3, 2'd3);
    chk("t8_stall_pre", 32'(stall_mask), 'b0011);
    #3 reset = 1'b0;
    #1;
    chk("t8_stall_rst", 32'(stall_mask), 'h0);
    chk("t8_busy_rst", 32'(busy), 'h0);
    chk("t8_ready_rst", 32'(req_ready), 'h0);
    chk("t8_relv_rst", 32'(rel_valid), 'h0);
    chk("t8_err_rst", 32'(err), 'h0);
    @(posedge clk);
    #3 reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t8_relv_post", 32'(rel_valid), 'h0);
      chk("t8_stall_post", 32'(stall_mask), 'h0);
    end
    arrive(2'd2, 2'd3, 2'd3);
    chk("t8_fresh_stall", 32'(stall_mask), 'b0100);
    chk("t8_fresh_relv", 32'(rel_valid), 'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
